// File: rtl/error_countdown_timer_pkg.sv
// Shared constants for the error countdown timer: error codes, countdown
// limits, FSM state encodings and the configuration clamp helper.
package error_countdown_timer_pkg;

  // Error codes reported by the matrix datapath; zero means "no error".
  localparam logic [3:0] ERR_NONE         = 4'd0;
  localparam logic [3:0] ERR_DIM_MISMATCH = 4'd1;
  localparam logic [3:0] ERR_ILLEGAL_OP   = 4'd2;
  localparam logic [3:0] ERR_OVERFLOW     = 4'd3;
  localparam logic [3:0] ERR_DIV_ZERO     = 4'd4;
  localparam logic [3:0] ERR_NOT_SQUARE   = 4'd5;
  localparam logic [3:0] ERR_SINGULAR     = 4'd6;

  // Countdown length limits in whole seconds (a single display digit).
  localparam logic [3:0] CD_MIN     = 4'd1;
  localparam logic [3:0] CD_MAX     = 4'd9;
  localparam logic [3:0] CD_DEFAULT = 4'd5;

  // FSM state encodings.
  localparam logic [0:0] CD_IDLE  = 1'b0;
  localparam logic [0:0] CD_COUNT = 1'b1;

  // Force a requested countdown length into CD_MIN..CD_MAX so the display
  // digit can never show 0 at load time or exceed 9.
  function automatic logic [3:0] clamp_secs(input logic [3:0] secs);
    logic [3:0] result;
    result = secs;
    if (secs < CD_MIN) begin
      result = CD_MIN;
    end else if (secs > CD_MAX) begin
      result = CD_MAX;
    end
    return result;
  endfunction

endpackage

// File: rtl/error_countdown_timer_tick.sv
// Free-running prescaler: emits a one-cycle tick every DIV enabled cycles.
// Also used by the display block to derive its blink rate.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Tick is combinational so the consumer acts on the same edge the count wraps.
  assign tick = en && (cnt == LAST);

  // Count enabled cycles; clr restarts the period from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/error_countdown_timer.sv
// Latches an error code and counts down whole seconds for the front-panel
// display. Pulses timeout for one cycle when the countdown expires.
// Input strobes (err_in, cancel, cfg_we) are single-cycle and sampled on the
// rising edge; there is no back-pressure, every strobe is acted on.
// Same-cycle priority: rst > valid error > cancel > tick.
module error_countdown_timer
  import error_countdown_timer_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int TICK_DIV     = 100_000_000,
  parameter int DEFAULT_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       err_in,
  input  logic [3:0] err_code_in,
  input  logic       cancel,
  input  logic       cfg_we,
  input  logic [3:0] cfg_secs,
  output logic [3:0] error_code,
  output logic [3:0] countdown_val,
  output logic       timeout,
  output logic       busy
);

  // Elaboration-time sanity checks on the parameters.
  if (CLK_FREQ < 1) begin : g_bad_freq
    $error("CLK_FREQ must be positive");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end
  if (DEFAULT_SECS < 1 || DEFAULT_SECS > 9) begin : g_bad_default
    $error("DEFAULT_SECS must be in 1..9");
  end

  localparam logic [3:0] RESET_SECS = 4'(DEFAULT_SECS);

  logic [0:0] state;      // current FSM state, CD_IDLE or CD_COUNT
  logic [3:0] cfg_reg;    // clamped countdown length used on the next load
  logic       valid_err;  // error strobe carrying a non-zero code
  logic       tick;       // one-second step from the prescaler
  logic       pre_clr;    // restart the prescaler period
  logic       pre_en;     // prescaler runs only while counting

  assign valid_err = err_in && (err_code_in != ERR_NONE);

  // Keep the prescaler parked at zero outside COUNT, and restart it on any
  // load or abort so every load begins a full period.
  assign pre_en  = (state == CD_COUNT);
  assign pre_clr = (state == CD_IDLE) || valid_err || cancel;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  // Configuration register: clamped on write, only consulted at load time.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_reg <= RESET_SECS;
    end else if (cfg_we) begin
      cfg_reg <= clamp_secs(cfg_secs);
    end
  end

  // Countdown FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CD_IDLE;
      error_code    <= ERR_NONE;
      countdown_val <= 4'd0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        CD_IDLE: begin
          if (valid_err) begin
            state         <= CD_COUNT;
            error_code    <= err_code_in;
            countdown_val <= cfg_reg;
            busy          <= 1'b1;
          end
        end
        CD_COUNT: begin
          if (valid_err) begin
            // Retrigger: new code, fresh count from the current setting.
            error_code    <= err_code_in;
            countdown_val <= cfg_reg;
            busy          <= 1'b1;
          end else if (cancel) begin
            state         <= CD_IDLE;
            error_code    <= ERR_NONE;
            countdown_val <= 4'd0;
            busy          <= 1'b0;
          end else if (tick) begin
            if (countdown_val > 4'd1) begin
              countdown_val <= countdown_val - 4'd1;
            end else begin
              // Final second elapsed: clear and tell the top FSM.
              state         <= CD_IDLE;
              error_code    <= ERR_NONE;
              countdown_val <= 4'd0;
              busy          <= 1'b0;
              timeout       <= 1'b1;
            end
          end
        end
        default: begin
          state         <= CD_IDLE;
          error_code    <= ERR_NONE;
          countdown_val <= 4'd0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_error_countdown_timer.sv
// Bench for error_countdown_timer: vector table, hand-written corner
// sequences, then randomized traffic against a time-based reference model.
module tb_error_countdown_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_in;
  logic [3:0] err_code_in;
  logic       cancel;
  logic       cfg_we;
  logic [3:0] cfg_secs;
  logic [3:0] error_code;
  logic [3:0] countdown_val;
  logic       timeout;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  error_countdown_timer #(
    .CLK_FREQ     (100_000_000),
    .TICK_DIV     (TD),
    .DEFAULT_SECS (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .err_in        (err_in),
    .err_code_in   (err_code_in),
    .cancel        (cancel),
    .cfg_we        (cfg_we),
    .cfg_secs      (cfg_secs),
    .error_code    (error_code),
    .countdown_val (countdown_val),
    .timeout       (timeout),
    .busy          (busy)
  );

  // ---------------- reference model ----------------
  // Tracks the count as elapsed cycles since the load edge; remaining
  // seconds are derived arithmetically from that.
  logic       m_active;
  logic [3:0] m_code;
  logic [3:0] m_secs;
  logic [3:0] m_cfg;
  logic       m_to;
  int         m_elapsed;

  task automatic model_edge();
    logic [3:0] old_cfg;
    if (rst) begin
      m_active = 1'b0; m_code = 4'd0; m_secs = 4'd0;
      m_cfg = 4'd5; m_to = 1'b0; m_elapsed = 0;
    end else begin
      old_cfg = m_cfg;
      m_to = 1'b0;
      if (cfg_we) m_cfg = (cfg_secs == 4'd0) ? 4'd1 : (cfg_secs > 4'd9) ? 4'd9 : cfg_secs;
      if (err_in && err_code_in != 4'd0) begin
        m_active = 1'b1; m_code = err_code_in; m_secs = old_cfg; m_elapsed = 0;
      end else if (m_active && cancel) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_elapsed++;
        if (m_elapsed == int'(m_secs) * TD) begin
          m_active = 1'b0;
          m_to = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [9:0] model_word();
    logic [3:0] c, v;
    c = m_active ? m_code : 4'd0;
    v = m_active ? 4'(int'(m_secs) - m_elapsed / TD) : 4'd0;
    return {c, v, m_to, m_active};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic e, input logic [3:0] c,
                      input logic x, input logic w, input logic [3:0] s);
    rst = r; err_in = e; err_code_in = c; cancel = x; cfg_we = w; cfg_secs = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp4(input string tag, input logic [3:0] c, input logic [3:0] v,
                      input logic t, input logic b);
    chk({tag, "_code"}, 10'(error_code), 10'(c));
    chk({tag, "_val"}, 10'(countdown_val), 10'(v));
    chk({tag, "_timeout"}, 10'(timeout), 10'(t));
    chk({tag, "_busy"}, 10'(busy), 10'(b));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       r, e;
    logic [3:0] c;
    logic       x, w;
    logic [3:0] s;
    logic [3:0] ec, ev;
    logic       et, eb;
    int         reps;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [3:0] c,
                     input logic x, input logic w, input logic [3:0] s,
                     input logic [3:0] ec, input logic [3:0] ev,
                     input logic et, input logic eb, input int reps);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.x = x; v.w = w; v.s = s;
    v.ec = ec; v.ev = ev; v.et = et; v.eb = eb; v.reps = reps;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] exp_w;
    rst = 1'b1; err_in = 1'b0; err_code_in = 4'd0;
    cancel = 1'b0; cfg_we = 1'b0; cfg_secs = 4'd0;

    // Basic countdown, cfg=5
    add(1,0,0,0,0,0,  0,0,0,0, 2);
    add(0,0,0,0,0,0,  0,0,0,0, 3);
    add(0,1,3,0,0,0,  3,5,0,1, 1);
    add(0,0,0,0,0,0,  3,5,0,1, 3);
    add(0,0,0,0,0,0,  3,4,0,1, 4);
    add(0,0,0,0,0,0,  3,3,0,1, 4);
    add(0,0,0,0,0,0,  3,2,0,1, 4);
    add(0,0,0,0,0,0,  3,1,0,1, 4);
    add(0,0,0,0,0,0,  0,0,1,0, 1);
    add(0,0,0,0,0,0,  0,0,0,0, 2);
    // Code 0 ignored, cancel in IDLE ignored
    add(0,1,0,0,0,0,  0,0,0,0, 2);
    add(0,0,0,1,0,0,  0,0,0,0, 2);
    // cfg 0 clamps to 1
    add(0,0,0,0,1,0,  0,0,0,0, 1);
    add(0,1,1,0,0,0,  1,1,0,1, 1);
    add(0,0,0,0,0,0,  1,1,0,1, 3);
    add(0,0,0,0,0,0,  0,0,1,0, 1);
    add(0,0,0,0,0,0,  0,0,0,0, 1);
    // cfg 12 clamps to 9, mid-count write of 7, cancel
    add(0,0,0,0,1,12, 0,0,0,0, 1);
    add(0,1,4,0,0,0,  4,9,0,1, 1);
    add(0,0,0,0,0,0,  4,9,0,1, 3);
    add(0,0,0,0,1,7,  4,8,0,1, 1);
    add(0,0,0,0,0,0,  4,8,0,1, 3);
    add(0,0,0,1,0,0,  0,0,0,0, 1);
    add(0,1,5,0,0,0,  5,7,0,1, 1);
    add(0,0,0,1,0,0,  0,0,0,0, 1);
    add(0,0,0,0,0,0,  0,0,0,0, 2);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        step(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].x, vecs[i].w, vecs[i].s);
        exp4($sformatf("vec%0d_%0d", i, k), vecs[i].ec, vecs[i].ev, vecs[i].et, vecs[i].eb);
      end
    end

    // Retrigger restarts value and prescaler; code 0 during COUNT ignored
    step(1,0,0,0,0,0);
    step(0,1,2,0,0,0);  exp4("t3_load", 2, 5, 0, 1);
    idle(13);           exp4("t3_before", 2, 2, 0, 1);
    step(0,1,6,0,0,0);  exp4("t3_retrig", 6, 5, 0, 1);
    step(0,1,0,0,0,0);  exp4("t3_code0", 6, 5, 0, 1);
    idle(2);            exp4("t3_k3", 6, 5, 0, 1);
    idle(1);            exp4("t3_k4", 6, 4, 0, 1);

    // Cancel on the final tick suppresses timeout
    step(1,0,0,0,0,0);
    step(0,0,0,0,1,1);
    step(0,1,9,0,0,0);  exp4("t4_load", 9, 1, 0, 1);
    idle(3);            exp4("t4_k3", 9, 1, 0, 1);
    step(0,0,0,1,0,0);  exp4("t4_cancel_tick", 0, 0, 0, 0);
    idle(1);            exp4("t4_after", 0, 0, 0, 0);

    // Valid error on the final tick retriggers without timeout
    step(1,0,0,0,0,0);
    step(0,0,0,0,1,2);
    step(0,1,7,0,0,0);  exp4("t5_load", 7, 2, 0, 1);
    idle(7);            exp4("t5_k7", 7, 1, 0, 1);
    step(0,1,8,0,0,0);  exp4("t5_err_tick", 8, 2, 0, 1);
    idle(1);            exp4("t5_after", 8, 2, 0, 1);

    // Reset with coincident error wins; cfg returns to 5
    step(1,0,0,0,0,0);
    step(0,0,0,0,1,2);
    step(0,1,3,0,0,0);  exp4("t6_load", 3, 2, 0, 1);
    idle(2);
    step(1,1,9,0,0,0);  exp4("t6_rst", 0, 0, 0, 0);
    step(0,1,4,0,0,0);  exp4("t6_reload", 4, 5, 0, 1);
    idle(19);           exp4("t6_k19", 4, 1, 0, 1);
    idle(1);            exp4("t6_expire", 0, 0, 1, 0);

    // Randomized traffic against the reference model
    step(1,0,0,0,0,0);
    for (int n = 0; n < 2000; n++) begin
      step(logic'($urandom_range(0, 499) == 0),
           logic'($urandom_range(0, 39) == 0),
           4'($urandom_range(0, 15)),
           logic'($urandom_range(0, 29) == 0),
           logic'($urandom_range(0, 24) == 0),
           4'($urandom_range(0, 15)));
      exp_q.push_back(model_word());
      exp_w = exp_q.pop_front();
      chk($sformatf("rand%0d", n), {error_code, countdown_val, timeout, busy}, exp_w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/error_countdown_timer.md
Name: error_countdown_timer

Overview:
Upstream feeder of the front-panel display controller. Latches a reported operand/dimension error code and runs a configurable whole-second countdown. Drives the `error_code` and `countdown_val` inputs that the display controller renders as 'E' plus a digit. Issues a one-cycle `timeout` pulse when the countdown expires, so the top FSM can drop back to the menu.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; documentation only.
- TICK_DIV, 100_000_000, clock cycles per countdown step (1 s at 100 MHz); benches override it to 4; must be ≥2.
- DEFAULT_SECS, 5, countdown length after reset; must be in 1..9.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `err_in`  in  1  one-cycle error report strobe.
- `err_code_in`  in  4  error code qualifying `err_in`; 0 means no error.
- `cancel`  in  1  user fixed the input; abort the countdown silently.
- `cfg_we`  in  1  write strobe from Setting mode.
- `cfg_secs`  in  4  new countdown length.
- `error_code`  out  4  latched active error; 0 when idle.
- `countdown_val`  out  4  seconds remaining, 0..9.
- `timeout`  out  1  one-cycle pulse on expiry.
- `busy`  out  1  high while counting.

Behaviour:
- All outputs are registered.
- Reset values: `error_code`=0, `countdown_val`=0, `timeout`=0, `busy`=0, state=IDLE, prescaler=0, cfg register=DEFAULT_SECS.
- Reset has priority over every other input in the same cycle. Reset mid-countdown returns all of the above to reset values on the next edge, with no `timeout` pulse.
- cfg register:
  - Written when `cfg_we`=1.
  - Clamped at write time: 0 is stored as 1, values >9 are stored as 9.
  - Writable in any state; a write during COUNT affects only the next load, never the running count.
- Valid error: `err_in`=1 and `err_code_in`≠0. `err_in` with code 0 is ignored entirely.
- States: IDLE and COUNT.
- IDLE, on a valid error sampled at edge N:
  - At edge N: state←COUNT, `busy`←1, `error_code`←`err_code_in`, `countdown_val`←cfg, prescaler←0.
  - These values are visible from cycle N+1.
- COUNT, prescaler:
  - Increments every cycle.
  - tick = (prescaler == TICK_DIV-1); on tick the prescaler wraps to 0.
- COUNT, on tick with `countdown_val`>1: `countdown_val` decrements.
- COUNT, on tick with `countdown_val`==1:
  - `countdown_val`←0, `error_code`←0, `busy`←0, `timeout`←1, state←IDLE.
  - `timeout` clears on the following edge.
- Total latency from the sampling edge to `timeout` visible is cfg×TICK_DIV cycles.
- COUNT, on a valid error (retrigger): reload as in IDLE with the new code and current cfg, prescaler←0, no `timeout`.
- COUNT, on `cancel`: state←IDLE, `error_code`←0, `countdown_val`←0, `busy`←0, no `timeout`. `cancel` is ignored in IDLE.
- Priority within one cycle: `rst` > valid error > `cancel` > tick.
  - A valid error coinciding with the final tick suppresses `timeout` and retriggers.
  - `cancel` coinciding with the final tick suppresses `timeout`.
- `countdown_val` never exceeds 9 and never wraps below 0.

Decomposition:
- Shared package `matrix_pkg.vh` holds:
  - ERR_NONE=4'd0 and the error code constants (dimension mismatch, illegal operand, ...).
  - CD_MIN=1, CD_MAX=9, CD_DEFAULT=5.
  - State encodings CD_IDLE and CD_COUNT.
- One natural sub-module: `tick_prescaler`.
  - Parameter DIV; inputs `clk`, `rst`, `clr`, `en`; output `tick`.
  - `tick` is a one-cycle pulse every DIV enabled cycles; `clr` zeroes the count.
  - Reused later for the display blink rate.

Test Plan (TICK_DIV=4, DEFAULT_SECS=5):
1. After reset, `err_in`=1 with code 3 at cycle 10 → `busy`=1, `error_code`=3, `countdown_val`=5 from cycle 11. Value steps 4,3,2,1 at cycles 15,19,23,27. Cycle 31: `countdown_val`=0, `error_code`=0, `busy`=0, `timeout`=1 for exactly one cycle.
2. `cfg_we` with `cfg_secs`=0 → next error loads 1, `timeout` 4 cycles after load edge. `cfg_secs`=12 → loads 9. `cfg_secs`=7 written mid-count → running count unchanged, next error loads 7.
3. Error code 2 running with `countdown_val`=2 → new error code 6 → `countdown_val`=5, `error_code`=6, prescaler restarted, no `timeout`. `err_in` with code 0 → no change.
4. `cancel` during COUNT → next cycle all outputs 0, `timeout` never asserted. `cancel` together with the final tick → no `timeout`. `cancel` in IDLE → no effect.
5. Valid error on the exact final-tick cycle → reload to cfg, no `timeout` pulse.
6. `rst` asserted mid-count together with `err_in` → all outputs 0 and cfg=5 next cycle. A second `err_in` afterwards loads 5.
